// File: rtl/hidden_cpu_feeder_if.sv
// Bus bundle between the host sequencer and its driver: program load port,
// run control, and the CPU io_in/io_out pair.
interface hidden_cpu_feeder_if;
    logic       clear;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_ready;
    logic       start;
    logic       pc_track;
    logic [7:0] cpu_out;
    logic [7:0] cpu_in;
    logic       busy;
    logic       done;
    logic [7:0] steps;

    modport master (
        output clear, load_valid, load_data, start, pc_track, cpu_out,
        input  load_ready, cpu_in, busy, done, steps
    );

    modport slave (
        input  clear, load_valid, load_data, start, pc_track, cpu_out,
        output load_ready, cpu_in, busy, done, steps
    );
endinterface

// File: rtl/hidden_cpu_feeder.sv
// Host-side program sequencer: loads 6-bit instructions, then resets the
// 8-bit CPU and single-steps it, fetching sequentially or from its PC.
module hidden_cpu_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    hidden_cpu_feeder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, RST_LO, RST_HI, SETUP, STROBE, DONE
    } state_e;

    state_e        state_q;
    logic [5:0]    mem_q [DEPTH];
    logic [AW:0]   cnt_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    steps_q;
    logic [7:0]    cpu_in_q;
    logic          busy_q;
    logic          done_q;
    logic          phase_q;

    logic          load_fire;
    logic          go;
    logic [8:0]    next_d;
    logic [8:0]    cnt_ext;
    logic [AW-1:0] next_addr;

    assign bus.load_ready = (state_q == IDLE) &&
                            (cnt_q < (AW+1)'(DEPTH));
    assign load_fire = bus.load_valid && bus.load_ready;
    assign go        = bus.start && !bus.clear && (cnt_q != '0);
    assign next_d    = bus.pc_track ? {1'b0, bus.cpu_out}
                                    : 9'(addr_q) + 9'd1;
    assign cnt_ext   = 9'(cnt_q);
    assign next_addr = next_d[AW-1:0];

    assign bus.cpu_in = cpu_in_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.steps  = steps_q;

    // Program memory survives reset and clear on purpose.
    always_ff @(posedge clk) begin
        if (load_fire)
            mem_q[cnt_q[AW-1:0]] <= bus.load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            steps_q  <= '0;
            cpu_in_q <= 8'h02;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.clear) begin
                        cnt_q <= '0;
                    end else begin
                        if (load_fire)
                            cnt_q <= cnt_q + 1'b1;
                        if (go) begin
                            state_q  <= RST_LO;
                            addr_q   <= '0;
                            steps_q  <= '0;
                            phase_q  <= 1'b0;
                            cpu_in_q <= 8'h02;
                            busy_q   <= 1'b1;
                        end
                    end
                end
                RST_LO: begin
                    state_q  <= RST_HI;
                    cpu_in_q <= 8'h03;
                end
                RST_HI: begin
                    if (phase_q) begin
                        state_q  <= SETUP;
                        cpu_in_q <= {mem_q[addr_q], 2'b00};
                    end else begin
                        phase_q  <= 1'b1;
                        state_q  <= RST_LO;
                        cpu_in_q <= 8'h02;
                    end
                end
                SETUP: begin
                    state_q  <= STROBE;
                    cpu_in_q <= {mem_q[addr_q], 2'b01};
                end
                STROBE: begin
                    steps_q <= steps_q + 8'd1;
                    if (next_d >= cnt_ext) begin
                        state_q  <= DONE;
                        cpu_in_q <= 8'h00;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q  <= SETUP;
                        addr_q   <= next_addr;
                        cpu_in_q <= {mem_q[next_addr], 2'b00};
                    end
                end
                DONE: begin
                    if (bus.clear) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        cpu_in_q <= 8'h02;
                        done_q   <= 1'b0;
                    end else if (bus.start) begin
                        state_q  <= RST_LO;
                        addr_q   <= '0;
                        steps_q  <= '0;
                        phase_q  <= 1'b0;
                        cpu_in_q <= 8'h02;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cpu_in_q <= 8'h02;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_cpu_feeder.sv
// Randomized bench for hidden_cpu_feeder with a step-level reference
// model of the program, fetch rule and cpu_in trace.
module tb_hidden_cpu_feeder;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hidden_cpu_feeder_if bus ();

    hidden_cpu_feeder #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp = 0;
    int nbad = 0;

    logic [5:0] mem_m [DEPTH];
    int         cnt_m = 0;
    logic [7:0] trace [$];
    logic [7:0] prev  [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cpu(input string tag, input logic [7:0] exp);
        chk(tag, 32'(bus.cpu_in), 32'(exp));
        trace.push_back(bus.cpu_in);
    endtask

    task automatic load_q(input logic [5:0] ws [$]);
        foreach (ws[i]) begin
            @(negedge clk);
            bus.load_valid = 1'b1;
            bus.load_data  = ws[i];
            chk("load_ready", 32'(bus.load_ready), 32'(cnt_m < DEPTH));
            if (cnt_m < DEPTH) begin
                mem_m[cnt_m] = ws[i];
                cnt_m++;
            end
        end
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk("ready_after_load", 32'(bus.load_ready), 32'(cnt_m < DEPTH));
    endtask

    task automatic load_rand(input int n);
        logic [5:0] ws [$];
        for (int i = 0; i < n; i++)
            ws.push_back(6'($urandom));
        load_q(ws);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        cnt_m = 0;
        chk("clear_ready", 32'(bus.load_ready), 32'd1);
        chk("clear_done", 32'(bus.done), 32'd0);
        chk("clear_cpu_in", 32'(bus.cpu_in), 32'h02);
    endtask

    // Walks one run step by step; fetch address follows the PC rule.
    task automatic run(input bit track, input bit pcdir, output int ncyc);
        int         a;
        int         s;
        logic [7:0] v;
        int         nx;
        trace.delete();
        bus.pc_track = track;
        pulse_start();
        ncyc = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                ncyc++;
            end
            chk_cpu("rst_phase", (k % 2 == 0) ? 8'h02 : 8'h03);
            chk("rst_busy", 32'(bus.busy), 32'd1);
        end
        a = 0;
        s = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ncyc++;
            chk_cpu("setup", {mem_m[a], 2'b00});
            if (!track)            v = 8'($urandom);
            else if (pcdir && i == 0) v = 8'd5;
            else if (pcdir && i == 1) v = 8'h20;
            else if (i >= 30)      v = 8'hFF;
            else                   v = 8'($urandom_range(0, cnt_m));
            bus.cpu_out = v;
            @(negedge clk);
            ncyc++;
            chk_cpu("strobe", {mem_m[a], 2'b01});
            chk("strobe_steps", 32'(bus.steps), 32'(s % 256));
            nx = track ? int'(v) : a + 1;
            s++;
            if (nx >= cnt_m) break;
            a = nx;
        end
        @(negedge clk);
        ncyc++;
        chk_cpu("done_cpu_in", 8'h00);
        chk("done_flag", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_steps", 32'(bus.steps), 32'(s % 256));
        chk("done_cycles", 32'(ncyc), 32'(5 + 2 * s));
    endtask

    initial begin
        int         nc;
        logic [7:0] exp3 [7];
        logic [5:0] ws [$];
        exp3 = '{8'h04, 8'h05, 8'h48, 8'h49, 8'h8C, 8'h8D, 8'h00};

        bus.clear      = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.pc_track   = 1'b0;
        bus.cpu_out    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cpu_in", 32'(bus.cpu_in), 32'h02);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_steps", 32'(bus.steps), 32'd0);
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        rst = 1'b0;

        pulse_start();
        @(negedge clk);
        chk("empty_busy", 32'(bus.busy), 32'd0);
        chk("empty_cpu_in", 32'(bus.cpu_in), 32'h02);

        ws = '{6'h01, 6'h12, 6'h23};
        load_q(ws);
        run(1'b0, 1'b0, nc);
        chk("seq_cycles", 32'(nc), 32'd11);
        chk("seq_steps", 32'(bus.steps), 32'd3);
        for (int i = 0; i < 7; i++)
            chk("seq_literal", 32'(trace[4+i]), 32'(exp3[i]));

        prev = trace;
        run(1'b0, 1'b0, nc);
        chk("retrace_len", 32'(trace.size()), 32'(prev.size()));
        for (int i = 0; i < trace.size() && i < prev.size(); i++)
            chk("retrace", 32'(trace[i]), 32'(prev[i]));

        @(negedge clk);
        bus.start = 1'b1;
        bus.clear = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        cnt_m = 0;
        chk("sc_busy", 32'(bus.busy), 32'd0);
        chk("sc_done", 32'(bus.done), 32'd0);
        chk("sc_ready", 32'(bus.load_ready), 32'd1);
        chk("sc_cpu_in", 32'(bus.cpu_in), 32'h02);
        pulse_start();
        chk("sc_restart_busy", 32'(bus.busy), 32'd0);

        load_rand(17);
        run(1'b0, 1'b0, nc);
        chk("full_steps", 32'(bus.steps), 32'd16);

        pulse_clear();
        load_rand(8);
        run(1'b1, 1'b1, nc);
        chk("pc_steps", 32'(bus.steps), 32'd2);

        for (int r = 0; r < 6; r++) begin
            pulse_clear();
            load_rand(int'($urandom_range(1, DEPTH)));
            run(1'($urandom), 1'b0, nc);
        end

        pulse_start();
        repeat (5) @(negedge clk);
        chk("mid_strobe", 32'(bus.cpu_in[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_cpu_in", 32'(bus.cpu_in), 32'h02);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_done", 32'(bus.done), 32'd0);
        chk("mid_steps", 32'(bus.steps), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0;
        pulse_start();
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_cpu_in", 32'(bus.cpu_in), 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/hidden_cpu_feeder.md
# hidden_cpu_feeder

Host-side program sequencer that drives the 8-bit CPU's `io_in` bus and reads back its `io_out` bus. It stores a short program of 6-bit instructions loaded through a valid/ready port. On `start` it resets the CPU, then steps the CPU clock one instruction at a time, presenting `{opcode, addrs}` on `cpu_in[7:2]`. The fetch address comes from an internal counter, or from the PC the CPU reports on `cpu_out` when the CPU is in PC-view mode.

## Interface
Parameters:
- `DEPTH`, 16: program memory entries (6 bits each); power of two, maximum 256.
- `AW`, 4: address width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock. One clock; all state is updated on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clear`  in  1  pulse; sets the load count to 0. Honoured in IDLE and DONE only.
- `load_valid`  in  1  a program word is offered.
- `load_data`  in  6  instruction word; bits [5:4] are the opcode, bits [3:0] are addrs.
- `load_ready`  out  1  the word is accepted when `load_valid && load_ready`.
- `start`  in  1  pulse; begins a run. Honoured in IDLE and DONE only.
- `pc_track`  in  1  0: fetch sequentially. 1: fetch from the PC on `cpu_out`. Sampled once per step.
- `cpu_out`  in  8  connects to the CPU's `io_out`.
- `cpu_in`  out  8  connects to the CPU's `io_in`. Bit 0 is the CPU clock, bit 1 is the CPU reset, bits [7:2] are the instruction.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high in DONE.
- `steps`  out  8  number of instructions strobed in the current run; wraps modulo 256.

## Operation
- Program memory is written only in IDLE, at address `load_count`.
  - `load_ready = (state==IDLE) && (load_count < DEPTH)`.
  - Each accepted word increments `load_count`, which is AW+1 bits wide.
  - When memory is full, `load_ready` is 0 and further `load_valid` is ignored.
- Memory contents are not reset or cleared. `clear` only zeroes `load_count`, and moves DONE to IDLE.
- `start` while `load_count==0` is ignored.
- `start` and `clear` asserted in the same cycle: `clear` wins and `start` is ignored.
- `start` while busy is ignored.

States:
- **IDLE**
  - `cpu_in = 8'h02`: CPU held in reset, CPU clock low, instruction 0.
  - On `start`: `addr <= 0`, `steps <= 0`, go to RST_LO.
- **RST_LO / RST_HI**
  - `cpu_in[1] = 1` throughout; `cpu_in[0]` is 0 in RST_LO and 1 in RST_HI.
  - The sequence runs RST_LO, RST_HI, RST_LO, RST_HI, giving two CPU reset edges. After the second RST_HI, go to SETUP.
- **SETUP**
  - `cpu_in = {mem[addr], 1'b0, 1'b0}`.
  - Go to STROBE.
- **STROBE**
  - `cpu_in = {mem[addr], 1'b0, 1'b1}`. The instruction is held identical to SETUP so it is stable across the CPU clock edge.
  - `steps <= steps + 1`.
  - Compute `next = pc_track ? cpu_out : addr + 1`, zero-extended to 9 bits.
  - If `next >= load_count`, go to DONE. Otherwise `addr <= next[AW-1:0]` and go to SETUP.
- **DONE**
  - `cpu_in = 8'h00`: CPU out of reset, clock low, so CPU state is preserved for inspection.
  - `done = 1`.
  - `start` restarts a run (to RST_LO). `clear` goes to IDLE.

Outputs and reset:
- `busy` is high in RST_LO, RST_HI, SETUP and STROBE.
- Reset values:
  - state: IDLE
  - `cpu_in`: 8'h02
  - `load_count`: 0
  - `addr`: 0
  - `steps`: 0
  - `busy`: 0
  - `done`: 0
  - `load_ready`: 1
- Asserting `rst` mid-run aborts immediately. `cpu_in` becomes 8'h02 asynchronously, which forces the CPU into reset.
- `cpu_in` is driven from registers only, with no combinational path from inputs, so the CPU clock is glitch-free.

## Timing
- Load accepts one word per cycle.
- From a `start` accepted at edge N:
  - RST_LO occupies cycle N+1.
  - The first SETUP occupies cycle N+5.
  - The first STROBE occupies cycle N+6.
- Each instruction takes exactly 2 `clk` cycles. A sequential run of L words reaches DONE at cycle N+5+2L.
- The CPU registers its PC on the 0→1 transition of `cpu_in[0]`, at the start of STROBE. The feeder samples `cpu_out` at the end of STROBE, so it sees the post-edge PC.
- `steps` increments on the edge that leaves STROBE.

## Test plan
- **Sequential load and run.** Reset, load 3 words (6'h01, 6'h12, 6'h23), pulse `start` with `pc_track=0`.
  - `cpu_in` sequence after the reset phase: 8'h04, 8'h05, 8'h48, 8'h49, 8'h8C, 8'h8D, then 8'h00.
  - `done` rises 11 cycles after `start`; `steps==3`.
- **Full memory.** Load 16 words.
  - `load_ready` falls after the 16th accept.
  - A 17th `load_valid` is ignored and `load_count` stays 16.
- **PC tracking.** Load 8 words, set `pc_track=1`, drive `cpu_out=5` during the first STROBE.
  - Second SETUP presents `mem[5]`.
  - Driving `cpu_out=8'h20` in a later STROBE gives DONE.
- **Start with empty memory.** With `load_count=0`, pulse `start` → state stays IDLE, `busy=0`, `cpu_in=8'h02`.
- **Reset mid-run.** Assert `rst` during a STROBE.
  - Same cycle: `cpu_in==8'h02`, `busy=0`, `done=0`, `steps=0`.
  - After release, `start` is ignored until new words are loaded.
- **DONE handling.**
  - Re-`start` from DONE repeats an identical `cpu_in` trace.
  - `clear` from DONE returns to IDLE with `load_ready=1`.
  - `start` and `clear` in the same cycle → `clear` wins.
